// File: rtl/ttt_ps2_keys.sv
// ttt_ps2_keys: PS/2 keyboard receiver and key decoder for the tic-tac-toe game.
// Synchronizes and glitch-filters the PS/2 lines, receives 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and turns make codes into
// single-cycle command pulses.
// Optional feature: define TTT_ARROW_KEYS_EN to map E0-prefixed arrow make
// codes onto up/down/left/right as well as the default WASD-style codes.
module ttt_ps2_keys #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  // Command vector order: {up, down, left, right, enter, space}
  localparam logic [5:0] CMD_NONE  = 6'b000000;
  localparam logic [5:0] CMD_UP    = 6'b100000;
  localparam logic [5:0] CMD_DOWN  = 6'b010000;
  localparam logic [5:0] CMD_LEFT  = 6'b001000;
  localparam logic [5:0] CMD_RIGHT = 6'b000100;
  localparam logic [5:0] CMD_ENTER = 6'b000010;
  localparam logic [5:0] CMD_SPACE = 6'b000001;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_s;
  logic            data_s;
  logic            filt_clk;
  logic [FW-1:0]   filt_cnt;
  logic            fall_edge;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [TW-1:0]   to_cnt;
  logic            break_pend;
  logic            ext_pend;
  logic [5:0]      cmd_next;
  logic            frame_good;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronizers; they reset high because an idle PS/2 bus is high,
  // so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock only follows the synchronized clock
  // after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s != filt_clk) begin
      if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // A falling edge is the cycle in which the filtered clock goes from 1 to 0.
  assign fall_edge = filt_clk & ~clk_s & (filt_cnt == FILT_LAST);

  // Frame is accepted when data plus parity has an odd number of ones and stop is 1.
  assign frame_good = (^{shift, parity_bit}) & data_s;

  // Decode the received byte into a command using the pending prefix flags.
  always_comb begin
    cmd_next = CMD_NONE;
    if (!break_pend && !ext_pend) begin
      case (shift)
        8'h1D:   cmd_next = CMD_UP;
        8'h1B:   cmd_next = CMD_DOWN;
        8'h1C:   cmd_next = CMD_LEFT;
        8'h23:   cmd_next = CMD_RIGHT;
        8'h5A:   cmd_next = CMD_ENTER;
        8'h29:   cmd_next = CMD_SPACE;
        default: cmd_next = CMD_NONE;
      endcase
    end
`ifdef TTT_ARROW_KEYS_EN
    else if (!break_pend && ext_pend) begin
      case (shift)
        8'h75:   cmd_next = CMD_UP;
        8'h72:   cmd_next = CMD_DOWN;
        8'h6B:   cmd_next = CMD_LEFT;
        8'h74:   cmd_next = CMD_RIGHT;
        default: cmd_next = CMD_NONE;
      endcase
    end
`endif
  end

  // Receiver FSM with timeout, prefix tracking and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      key_code   <= 8'h00;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      enter      <= 1'b0;
      space      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      {up, down, left, right, enter, space} <= CMD_NONE;

      if (state != IDLE && !fall_edge) begin
        if (to_cnt == TO_LAST) begin
          state     <= IDLE;
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
        if (fall_edge) begin
          case (state)
            IDLE: begin
              if (!data_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift   <= {data_s, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end
            PARITY: begin
              parity_bit <= data_s;
              state      <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (frame_good) begin
                key_code  <= shift;
                key_valid <= 1'b1;
                {up, down, left, right, enter, space} <= cmd_next;
                if (shift == 8'hF0) begin
                  break_pend <= 1'b1;
                end else if (shift == 8'hE0) begin
                  ext_pend <= 1'b1;
                end else begin
                  break_pend <= 1'b0;
                  ext_pend   <= 1'b0;
                end
              end else begin
                frame_err  <= 1'b1;
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ttt_ps2_keys.sv
// tb_ttt_ps2_keys: scoreboard bench for ttt_ps2_keys.
// Stimulus pushes the expected response of each frame into a queue; an
// independent monitor pops and compares whenever the DUT pulses an output.
module tb_ttt_ps2_keys;

  localparam int TIMEOUT = 300;
  localparam int FILT    = 4;
  localparam int HALF    = 10;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] UP    = 6'b100000;
  localparam logic [5:0] DOWN  = 6'b010000;
  localparam logic [5:0] LEFT  = 6'b001000;
  localparam logic [5:0] RIGHT = 6'b000100;
  localparam logic [5:0] ENTER = 6'b000010;
  localparam logic [5:0] SPACE = 6'b000001;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic [5:0] cmd;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       up, down, left, right, enter, space;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic [5:0] cmds;

  exp_t       sb[$];
  logic [7:0] last_code;
  int         checks;
  int         errors;

  assign cmds = {up, down, left, right, enter, space};

  ttt_ps2_keys #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN(FILT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .enter(enter),
    .space(space),
    .key_code(key_code),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic sendBits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Send one full frame and record the response expected for it
  task automatic applyStimulus(input logic [7:0] b, input logic bad_parity,
                               input logic [5:0] exp_cmd);
    exp_t e;
    logic par;
    par    = ~(^b) ^ bad_parity;
    e.err  = bad_parity;
    e.code = bad_parity ? last_code : b;
    e.cmd  = bad_parity ? NONE : exp_cmd;
    if (!bad_parity) last_code = b;
    sb.push_back(e);
    sendBits({1'b1, par, b, 1'b0}, 11);
  endtask

  task automatic checkQuiet(input string name);
    checkOutput({name, "_key_valid"}, int'(key_valid), 0);
    checkOutput({name, "_frame_err"}, int'(frame_err), 0);
    checkOutput({name, "_cmds"}, int'(cmds), 0);
    checkOutput({name, "_key_code"}, int'(key_code), 0);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && (key_valid || frame_err || cmds != NONE)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: actual valid=%0b err=%0b code=0x%0h cmds=%b required=no pulse",
                 key_valid, frame_err, key_code, cmds);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("frame_err", int'(frame_err), int'(e.err));
        checkOutput("key_valid", int'(key_valid), int'(!e.err));
        checkOutput("key_code", int'(key_code), int'(e.code));
        checkOutput("cmds", int'(cmds), int'(e.cmd));
      end
    end
  end

  initial begin
    exp_t e;
    checks    = 0;
    errors    = 0;
    last_code = 8'h00;
    reset     = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    repeat (5) @(negedge clk);
    checkQuiet("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] basic make code");
    applyStimulus(8'h1D, 1'b0, UP);

    $display("[TB] make, break, make of space");
    applyStimulus(8'h29, 1'b0, SPACE);
    applyStimulus(8'hF0, 1'b0, NONE);
    applyStimulus(8'h29, 1'b0, NONE);

    $display("[TB] parity error then good enter");
    applyStimulus(8'h5A, 1'b1, NONE);
    applyStimulus(8'h5A, 1'b0, ENTER);

    $display("[TB] typematic repeat and unmapped code");
    applyStimulus(8'h1B, 1'b0, DOWN);
    applyStimulus(8'h1B, 1'b0, DOWN);
    applyStimulus(8'h15, 1'b0, NONE);

    $display("[TB] bad stop bit");
    e.err = 1'b1; e.code = last_code; e.cmd = NONE;
    sb.push_back(e);
    sendBits({1'b0, ~(^8'h1C), 8'h1C, 1'b0}, 11);

    $display("[TB] partial frame timeout");
    e.err = 1'b1; e.code = last_code; e.cmd = NONE;
    sb.push_back(e);
    sendBits({1'b1, 1'b0, 8'h44, 1'b0}, 5);
    repeat (TIMEOUT + 10) @(negedge clk);
    applyStimulus(8'h23, 1'b0, RIGHT);

    $display("[TB] extended codes");
    applyStimulus(8'hE0, 1'b0, NONE);
`ifdef TTT_ARROW_KEYS_EN
    applyStimulus(8'h75, 1'b0, UP);
`else
    applyStimulus(8'h75, 1'b0, NONE);
`endif
    applyStimulus(8'hE0, 1'b0, NONE);
    applyStimulus(8'hF0, 1'b0, NONE);
    applyStimulus(8'h75, 1'b0, NONE);
    applyStimulus(8'h1C, 1'b0, LEFT);

    $display("[TB] reset mid-frame");
    sendBits({1'b1, 1'b0, 8'h55, 1'b0}, 6);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkQuiet("midreset");
    reset     = 1'b0;
    last_code = 8'h00;
    repeat (10) @(negedge clk);
    applyStimulus(8'h1C, 1'b0, LEFT);

    $display("[TB] clock glitches");
    ps2_data = 1'b0;
    for (int g = 1; g < FILT; g++) begin
      repeat (4) begin
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (g) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (8) @(negedge clk);
      end
    end
    ps2_data = 1'b1;
    repeat (TIMEOUT + 20) @(negedge clk);
    applyStimulus(8'h1D, 1'b0, UP);

    repeat (50) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_ps2_keys.md
TTT_PS2_KEYS -- requirements
Module: ttt_ps2_keys

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, is the number of clk cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-002 Parameter FILTER_LEN, default 4, is the number of consecutive equal synchronized ps2_clk samples needed to accept a level change.
REQ-003 clk  input  1  system clock; reset is asynchronous, active-high.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  PS/2 device clock; asynchronous to clk.
REQ-006 ps2_data  input  1  PS/2 device data; asynchronous to clk.
REQ-007 up, down, left, right, enter, space  output  1 each  single-cycle command pulses to the game controller.
REQ-008 key_code  output  8  last correctly received frame byte.
REQ-009 key_valid  output  1  single-cycle pulse; key_code was updated.
REQ-010 frame_err  output  1  single-cycle pulse; frame was discarded.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; ps2_clk SHALL then be glitch-filtered per FILTER_LEN.
REQ-012 A falling edge SHALL be a filtered ps2_clk transition from 1 to 0, and ps2_data SHALL be sampled on that cycle.
REQ-013 Receiver FSM SHALL use states IDLE, DATA, PARITY, STOP; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-014 In IDLE, an edge with data=1 SHALL be ignored (remain IDLE); an edge with data=0 SHALL go to DATA with bit count 0.
REQ-015 DATA SHALL shift in 8 bits, then go to PARITY; PARITY SHALL record the bit and go to STOP; STOP SHALL always return to IDLE.
REQ-016 At the STOP edge, if parity is odd and stop=1: on the next clk, key_code SHALL take the byte and key_valid SHALL pulse.
REQ-017 At the STOP edge, a parity error or stop=0 SHALL discard the byte, pulse frame_err on the next clk, and clear both prefix flags.
REQ-018 Outside IDLE, TIMEOUT_CYCLES consecutive clk cycles without an edge SHALL force IDLE, clear the bit count, and pulse frame_err once.
REQ-019 Decode: byte 0xF0 SHALL set break_pend; byte 0xE0 SHALL set ext_pend; neither byte SHALL drive a command pulse.
REQ-020 Every other valid byte SHALL clear both flags after decoding; if break_pend was set, no command pulse SHALL be issued.
REQ-021 Make codes with ext_pend clear SHALL map 0x1D->up, 0x1B->down, 0x1C->left, 0x23->right, 0x5A->enter, 0x29->space; other codes SHALL produce no pulse.
REQ-022 A command pulse SHALL be high for exactly one clk, in the same cycle as key_valid; at most one command SHALL be asserted per cycle.
REQ-023 Typematic repeats (repeated make codes) SHALL each produce a new pulse.
REQ-024 Extended make codes SHALL produce no pulse unless TTT_ARROW_KEYS_EN is defined.

Reset
REQ-025 reset SHALL asynchronously force the FSM to IDLE and clear the bit count, shift register, timeout counter, filter, break_pend and ext_pend.
REQ-026 During reset all outputs SHALL be 0 (key_code = 8'h00); a partial frame in progress at reset SHALL be lost with no frame_err.
REQ-027 Synchronizers SHALL reset to 1 (PS/2 idle-high) so that reset release causes no false edge.

Configuration
REQ-028 With macro TTT_ARROW_KEYS_EN defined, ext_pend make codes SHALL map E0 75->up, E0 72->down, E0 6B->left, E0 74->right; WASD SHALL still work.
REQ-029 With TTT_ARROW_KEYS_EN undefined, E0-prefixed make codes SHALL be consumed silently, and E0 handling SHALL only clear flags.

Verification
REQ-030 Frame 0x1D, correct parity -> key_code=0x1D, key_valid and up each high exactly 1 clk; no other outputs asserted.
REQ-031 Sequence 0x29, F0, 0x29 -> exactly one space pulse, three key_valid pulses, no frame_err.
REQ-032 Frame 0x5A with parity bit inverted -> frame_err pulse, no enter pulse, key_code unchanged; a following good 0x5A -> enter pulse.
REQ-033 Send 5 bits of a frame, then idle ps2_clk high for TIMEOUT_CYCLES+10 cycles -> one frame_err pulse; a following good 0x23 -> right pulse.
REQ-034 E0, 0x75 -> up pulse with TTT_ARROW_KEYS_EN defined; no command pulse without it; E0, F0, 0x75 -> no pulse in either build.
REQ-035 Assert reset mid-frame after 6 edges, release, send 0x1C -> left pulse; 1-cycle ps2_clk glitches (< FILTER_LEN) -> no edges accepted.
